// File: rtl/seg_scan_driver_if.sv
// Bundles the shadow-load inputs and the scanned display outputs of seg_scan_driver.
interface seg_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    lz_suppress;
  logic                    load;
  logic [6:0]              hex;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;

  modport master (
    output value, dp_in, digit_en, lz_suppress, load,
    input  hex, dp, an
  );

  modport slave (
    input  value, dp_in, digit_en, lz_suppress, load,
    output hex, dp, an
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Multiplexed common-anode hex display scanner with blanking, per-digit enable,
// decimal points, leading-zero suppression and a load-synchronised shadow register.
module seg_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYCLES   = 1,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic               clk,
  input  logic               rst,
  seg_scan_driver_if.slave   bus
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] AN_OFF = (AN_ACTIVE_LOW != 0) ? '1 : '0;

  logic [DW-1:0]           r_div_cnt;
  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_value;
  logic [NUM_DIGITS-1:0]   r_dp;
  logic [NUM_DIGITS-1:0]   r_en;
  logic                    r_lz;
  logic [6:0]              r_hex;
  logic                    r_dpo;
  logic [NUM_DIGITS-1:0]   r_an;

  logic [IW-1:0]           w_top;
  logic [3:0]              w_nib;
  logic                    w_en_sel;
  logic                    w_dp_sel;
  logic [NUM_DIGITS-1:0]   w_onehot;
  logic                    w_blank;
  logic                    w_lit;
  logic [6:0]              w_seg_lit;
  logic [NUM_DIGITS-1:0]   w_an_lit;

  function automatic logic [6:0] seg_encode(input logic [3:0] n);
    case (n)
      4'h0: seg_encode = 7'b1000000;
      4'h1: seg_encode = 7'b1111001;
      4'h2: seg_encode = 7'b0100100;
      4'h3: seg_encode = 7'b0110000;
      4'h4: seg_encode = 7'b0011001;
      4'h5: seg_encode = 7'b0010010;
      4'h6: seg_encode = 7'b0000010;
      4'h7: seg_encode = 7'b1111000;
      4'h8: seg_encode = 7'b0000000;
      4'h9: seg_encode = 7'b0010000;
      4'hA: seg_encode = 7'b0001000;
      4'hB: seg_encode = 7'b0000011;
      4'hC: seg_encode = 7'b1000110;
      4'hD: seg_encode = 7'b0100001;
      4'hE: seg_encode = 7'b0000110;
      default: seg_encode = 7'b0001110;
    endcase
  endfunction

  // Highest non-zero nibble; digits above it count as leading zeros.
  always_comb begin
    w_top = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (r_value[4*i +: 4] != 4'h0) w_top = IW'(i);
    end
  end

  always_comb begin
    w_nib    = '0;
    w_en_sel = 1'b0;
    w_dp_sel = 1'b0;
    w_onehot = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IW'(i)) begin
        w_nib       = r_value[4*i +: 4];
        w_en_sel    = r_en[i];
        w_dp_sel    = r_dp[i];
        w_onehot[i] = 1'b1;
      end
    end
  end

  generate
    if (BLANK_CYCLES == 0) begin : g_noblank
      assign w_blank = 1'b0;
    end else begin : g_blank
      assign w_blank = (r_div_cnt < DW'(BLANK_CYCLES));
    end
  endgenerate

  assign w_lit     = !w_blank && w_en_sel && !(r_lz && (r_idx > w_top));
  assign w_seg_lit = (SEG_ACTIVE_LOW != 0) ? seg_encode(w_nib) : ~seg_encode(w_nib);
  assign w_an_lit  = (AN_ACTIVE_LOW != 0) ? ~w_onehot : w_onehot;

  // Outputs are decided from pre-edge counter and shadow, so a load never tears a digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt <= '0;
      r_idx     <= '0;
      r_value   <= '0;
      r_dp      <= '0;
      r_en      <= '0;
      r_lz      <= 1'b0;
      r_hex     <= SEG_OFF;
      r_dpo     <= DP_OFF;
      r_an      <= AN_OFF;
    end else begin
      if (r_div_cnt == DW'(SCAN_DIV - 1)) begin
        r_div_cnt <= '0;
        if (r_idx == IW'(NUM_DIGITS - 1)) r_idx <= '0;
        else                              r_idx <= r_idx + 1'b1;
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
      end
      if (bus.load) begin
        r_value <= bus.value;
        r_dp    <= bus.dp_in;
        r_en    <= bus.digit_en;
        r_lz    <= bus.lz_suppress;
      end
      r_hex <= w_lit ? w_seg_lit : SEG_OFF;
      r_dpo <= (w_lit && w_dp_sel) ? ~DP_OFF : DP_OFF;
      r_an  <= w_lit ? w_an_lit : AN_OFF;
    end
  end

  assign bus.hex = r_hex;
  assign bus.dp  = r_dpo;
  assign bus.an  = r_an;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: 4-digit main instance plus 1- and 8-digit sweeps.
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] t_value = '0;
  logic [7:0]  t_dp = '0;
  logic [7:0]  t_en = '0;
  logic        t_lz = 1'b0;
  logic        t_load = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg_scan_driver_if #(.NUM_DIGITS(4)) if4 ();
  seg_scan_driver_if #(.NUM_DIGITS(1)) if1 ();
  seg_scan_driver_if #(.NUM_DIGITS(8)) if8 ();

  assign if4.value = t_value[15:0];
  assign if4.dp_in = t_dp[3:0];
  assign if4.digit_en = t_en[3:0];
  assign if4.lz_suppress = t_lz;
  assign if4.load = t_load;
  assign if1.value = t_value[3:0];
  assign if1.dp_in = t_dp[0:0];
  assign if1.digit_en = t_en[0:0];
  assign if1.lz_suppress = t_lz;
  assign if1.load = t_load;
  assign if8.value = t_value;
  assign if8.dp_in = t_dp;
  assign if8.digit_en = t_en;
  assign if8.lz_suppress = t_lz;
  assign if8.load = t_load;

  seg_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLANK_CYCLES(1),
                    .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1))
    dut4 (.clk(clk), .rst(rst), .bus(if4));
  seg_scan_driver #(.NUM_DIGITS(1), .SCAN_DIV(4), .BLANK_CYCLES(0),
                    .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1))
    dut1 (.clk(clk), .rst(rst), .bus(if1));
  seg_scan_driver #(.NUM_DIGITS(8), .SCAN_DIV(4), .BLANK_CYCLES(0),
                    .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1))
    dut8 (.clk(clk), .rst(rst), .bus(if8));

  localparam logic [6:0] SEG_TAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  localparam int M_N  [3] = '{4, 1, 8};
  localparam int M_BL [3] = '{1, 0, 0};
  localparam int M_SD = 4;

  int          m_cnt [3] = '{0, 0, 0};
  int          m_idx [3] = '{0, 0, 0};
  logic [31:0] m_val [3] = '{0, 0, 0};
  logic [7:0]  m_dpv [3] = '{0, 0, 0};
  logic [7:0]  m_en  [3] = '{0, 0, 0};
  logic        m_lz  [3] = '{0, 0, 0};

  typedef struct {
    int         m;
    logic [7:0] an;
    logic [6:0] hex;
    logic       dp;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input int m, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp)
      else begin
        errors++;
        $error("FAIL %s inst%0d got %b want %b", tag, m, got, exp);
      end
  endtask

  function automatic logic [7:0] act_an(input int m);
    if (m == 0)      act_an = {4'hF, if4.an};
    else if (m == 1) act_an = {7'h7F, if1.an};
    else             act_an = if8.an;
  endfunction

  function automatic logic [6:0] act_hex(input int m);
    if (m == 0)      act_hex = if4.hex;
    else if (m == 1) act_hex = if1.hex;
    else             act_hex = if8.hex;
  endfunction

  function automatic logic act_dp(input int m);
    if (m == 0)      act_dp = if4.dp;
    else if (m == 1) act_dp = if1.dp;
    else             act_dp = if8.dp;
  endfunction

  // Predict each instance's outputs for this edge, advance the model, clock, then score.
  task automatic step();
    exp_t e;
    int n, top, nib;
    bit lit;
    logic [63:0] vm;
    logic [15:0] dm;
    for (int m = 0; m < 3; m++) begin
      n = M_N[m];
      top = 0;
      for (int d = 0; d < n; d++)
        if (((m_val[m] >> (4 * d)) & 32'hF) != 0) top = d;
      lit = (m_cnt[m] >= M_BL[m]) && (m_en[m][m_idx[m]] == 1'b1) &&
            !(m_lz[m] && (m_idx[m] > top));
      e.m = m;
      if (!rst && lit) begin
        nib   = int'((m_val[m] >> (4 * m_idx[m])) & 32'hF);
        e.an  = ~(8'd1 << m_idx[m]);
        e.hex = SEG_TAB[nib];
        e.dp  = ~m_dpv[m][m_idx[m]];
      end else begin
        e.an  = 8'hFF;
        e.hex = 7'h7F;
        e.dp  = 1'b1;
      end
      sb.push_back(e);
      if (rst) begin
        m_cnt[m] = 0; m_idx[m] = 0; m_val[m] = '0;
        m_dpv[m] = '0; m_en[m] = '0; m_lz[m] = 1'b0;
      end else begin
        if (m_cnt[m] == M_SD - 1) begin
          m_cnt[m] = 0;
          m_idx[m] = (m_idx[m] + 1) % n;
        end else begin
          m_cnt[m] = m_cnt[m] + 1;
        end
        if (t_load) begin
          vm = (64'd1 << (4 * n)) - 64'd1;
          dm = (16'd1 << n) - 16'd1;
          m_val[m] = t_value & vm[31:0];
          m_dpv[m] = t_dp & dm[7:0];
          m_en[m]  = t_en & dm[7:0];
          m_lz[m]  = t_lz;
        end
      end
    end
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk("an",  e.m, act_an(e.m), e.an);
      chk("hex", e.m, {1'b0, act_hex(e.m)}, {1'b0, e.hex});
      chk("dp",  e.m, {7'b0, act_dp(e.m)}, {7'b0, e.dp});
    end
  endtask

  task automatic run(input int cycles);
    for (int k = 0; k < cycles; k++) step();
  endtask

  task automatic do_load(input logic [31:0] v, input logic [7:0] en, input logic [7:0] dpv,
                         input logic lz);
    t_value = v; t_en = en; t_dp = dpv; t_lz = lz; t_load = 1'b1;
    step();
    t_load = 1'b0;
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    run(2);
    rst = 1'b0;

    // Basic scan, with directed check of the first lit digit
    do_load(32'h0000_12AF, 8'h0F, 8'h00, 1'b0);
    step();
    chk("basic_an0", 0, {4'hF, if4.an}, 8'hFE);
    chk("basic_hexF", 0, {1'b0, if4.hex}, 8'b0000_1110);
    chk("basic_dp0", 0, {7'b0, if4.dp}, 8'h01);
    run(20);

    // Leading-zero suppression
    do_load(32'h0000_0030, 8'h0F, 8'h00, 1'b1);
    run(20);
    do_load(32'h0000_0000, 8'h0F, 8'h00, 1'b1);
    run(20);

    // Masking and decimal point
    do_load(32'h0000_8888, 8'h05, 8'h04, 1'b0);
    run(20);

    // Shadow isolation
    do_load(32'h0000_1234, 8'h0F, 8'h00, 1'b0);
    t_value = 32'hFFFF_FFFF;
    run(32);
    do_load(32'hFFFF_FFFF, 8'h0F, 8'h00, 1'b0);
    run(10);

    // Reset mid-scan, during digit 2's lit interval
    for (int k = 0; k < 40 && !(m_idx[0] == 2 && m_cnt[0] == 2); k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    run(20);

    // Parameter sweep: 1- and 8-digit instances must never go dark with BLANK_CYCLES=0
    do_load(32'h1357_9BDF, 8'hFF, 8'hA5, 1'b0);
    for (int k = 0; k < 64; k++) begin
      step();
      chk("n1_never_dark", 1, {7'b0, (if1.an == 1'b1)}, 8'h00);
      chk("n8_never_dark", 2, {7'b0, (if8.an == 8'hFF)}, 8'h00);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
